// File: rtl/dca_matrix_lsu_inst_pkg.sv
// Shared definitions for the DCA matrix-LSU store path: FSM encoding, txn-info field widths, packing order.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dca_matrix_lsu_inst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int BW_DCA_MATRIX_INFO_ADDR     = 32;
    localparam int BW_DCA_MATRIX_INFO_ALEN     = 8;
    localparam int BW_DCA_MATRIX_INFO_IS_FIRST = 1;
    localparam int BW_DCA_MATRIX_INFO_IS_LAST  = 1;
    localparam int BW_DCA_MATRIX_INFO          = BW_DCA_MATRIX_INFO_ADDR + BW_DCA_MATRIX_INFO_ALEN
                                               + BW_DCA_MATRIX_INFO_IS_FIRST + BW_DCA_MATRIX_INFO_IS_LAST;

    // Packing order {is_last, is_first, alen, addr}; the write-data unformatter unpacks with this same struct.
    typedef struct packed {
        logic                               is_last;
        logic                               is_first;
        logic [BW_DCA_MATRIX_INFO_ALEN-1:0] alen;
        logic [BW_DCA_MATRIX_INFO_ADDR-1:0] addr;
    } dca_matrix_info_t;

    function automatic dca_matrix_info_t pack_matrix_info(
        input logic                               is_last,
        input logic                               is_first,
        input logic [BW_DCA_MATRIX_INFO_ALEN-1:0] alen,
        input logic [BW_DCA_MATRIX_INFO_ADDR-1:0] addr
    );
        dca_matrix_info_t info;
        info.is_last  = is_last;
        info.is_first = is_first;
        info.alen     = alen;
        info.addr     = addr;
        return info;
    endfunction

endpackage

// File: rtl/dca_outstanding_counter.sv
// Up/down count of issued-but-unacknowledged rows with full/empty flags and an underflow guard.
// Latency: count updates on the clock edge after inc/dec; flags are combinational from the count.
// Backpressure: none internally; caller must not inc while full. dec while empty is dropped (dec_taken=0).
// Ports: clk, rstnn (sync active-low), clr (sync clear), inc, dec -> cnt, full, empty, dec_taken.
module dca_outstanding_counter #(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             dec_taken
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_MAX);
    assign dec_taken = dec && !empty;

    // Simultaneous inc and accepted dec cancel out.
    always_ff @(posedge clk) begin
        if (!rstnn || clr) begin
            cnt <= '0;
        end else if (inc && !dec_taken) begin
            cnt <= cnt + CNT_ONE;
        end else if (!inc && dec_taken) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/dca_matrix_store_sequencer.sv
// Splits one matrix store instruction into per-row write txns (row order) and tracks their B responses.
// Latency: first txn 1 cycle after accept, then one row per cycle; done 1 cycle after the final response is counted.
// Backpressure: txn held stable while txn_ready=0; issue stalls at MAX_OUTSTANDING; inst_ready only in IDLE.
// Ports: inst_* (decoded store in), txn_* (row info out), resp_valid/resp_error (B channel), busy/done/error status.
module dca_matrix_store_sequencer
    import dca_matrix_lsu_inst_pkg::*;
#(
    parameter int BW_ADDR         = 32,
    parameter int BW_NUM_ROW_M1   = 8,
    parameter int BW_NUM_COL_M1   = 8,
    parameter int BW_STRIDE_LS3   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [BW_ADDR-1:0]       inst_addr,
    input  logic [BW_STRIDE_LS3-1:0] inst_stride_ls3,
    input  logic [BW_NUM_ROW_M1-1:0] inst_num_row_m1,
    input  logic [BW_NUM_COL_M1-1:0] inst_num_col_m1,
    output logic                     txn_valid,
    input  logic                     txn_ready,
    output logic [BW_ADDR-1:0]       txn_addr,
    output logic [BW_NUM_COL_M1-1:0] txn_alen,
    output logic                     txn_is_first,
    output logic                     txn_is_last,
    input  logic                     resp_valid,
    input  logic                     resp_error,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [BW_NUM_ROW_M1-1:0] ROW_ONE  = BW_NUM_ROW_M1'(1);
    localparam logic [BW_NUM_ROW_M1:0]   RESP_ONE = (BW_NUM_ROW_M1 + 1)'(1);

    seq_state_t               state_q, state_d;
    logic [BW_ADDR-1:0]       row_addr_q;
    logic [BW_NUM_ROW_M1-1:0] row_cnt_q;
    logic [BW_NUM_ROW_M1-1:0] num_row_m1_q;
    logic [BW_NUM_COL_M1-1:0] num_col_m1_q;
    logic [BW_STRIDE_LS3-1:0] stride_ls3_q;
    logic [BW_NUM_ROW_M1:0]   resp_cnt_q;
    logic                     err_q;

    logic [OUT_W-1:0] out_cnt;
    logic             out_full;
    logic             out_empty;
    logic             resp_taken;

    logic inst_fire;
    logic txn_fire;
    logic row_last;
    logic all_resp;

    assign inst_fire = inst_valid && inst_ready;
    assign txn_fire  = txn_valid && txn_ready;
    assign row_last  = (row_cnt_q == num_row_m1_q);
    assign all_resp  = (resp_cnt_q == ((BW_NUM_ROW_M1 + 1)'(num_row_m1_q) + RESP_ONE));

    // Responses in IDLE are stale (e.g. after a mid-instruction reset) and never reach the counter.
    dca_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk       (clk),
        .rstnn     (rstnn),
        .clr       (state_q == ST_IDLE),
        .inc       (txn_fire),
        .dec       (resp_valid && (state_q != ST_IDLE)),
        .cnt       (out_cnt),
        .full      (out_full),
        .empty     (out_empty),
        .dec_taken (resp_taken)
    );

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (inst_valid)           state_d = ST_ISSUE;
            ST_ISSUE: if (txn_fire && row_last) state_d = ST_DRAIN;
            ST_DRAIN: if (all_resp)             state_d = ST_DONE;
            ST_DONE:                            state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Payload is gated to zero outside ISSUE so idle outputs match the reset values.
    always_comb begin
        inst_ready   = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        txn_valid    = 1'b0;
        txn_addr     = '0;
        txn_alen     = '0;
        txn_is_first = 1'b0;
        txn_is_last  = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        if (state_q == ST_ISSUE) begin
            txn_valid    = !out_full;
            txn_addr     = row_addr_q;
            txn_alen     = num_col_m1_q;
            txn_is_first = (row_cnt_q == '0);
            txn_is_last  = row_last;
        end
        if (state_q == ST_DONE) begin
            done  = 1'b1;
            error = err_q;
        end
    end

    // Row address generator and response bookkeeping. Stride add wraps modulo 2^BW_ADDR.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            row_addr_q   <= '0;
            row_cnt_q    <= '0;
            num_row_m1_q <= '0;
            num_col_m1_q <= '0;
            stride_ls3_q <= '0;
            resp_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else if (inst_fire) begin
            row_addr_q   <= inst_addr;
            row_cnt_q    <= '0;
            num_row_m1_q <= inst_num_row_m1;
            num_col_m1_q <= inst_num_col_m1;
            stride_ls3_q <= inst_stride_ls3;
            resp_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            if (txn_fire) begin
                row_addr_q <= row_addr_q + BW_ADDR'({stride_ls3_q, 3'b000});
                row_cnt_q  <= row_cnt_q + ROW_ONE;
            end
            if (resp_taken) begin
                resp_cnt_q <= resp_cnt_q + RESP_ONE;
                err_q      <= err_q | resp_error;
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_store_sequencer.sv
module tb_dca_matrix_store_sequencer;

    logic        clk;
    logic        rstnn;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [15:0] inst_stride_ls3;
    logic [7:0]  inst_num_row_m1;
    logic [7:0]  inst_num_col_m1;
    logic        txn_valid;
    logic        txn_ready;
    logic [31:0] txn_addr;
    logic [7:0]  txn_alen;
    logic        txn_is_first;
    logic        txn_is_last;
    logic        resp_valid;
    logic        resp_error;
    logic        busy;
    logic        done;
    logic        error;

    dca_matrix_store_sequencer dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_addr       (inst_addr),
        .inst_stride_ls3 (inst_stride_ls3),
        .inst_num_row_m1 (inst_num_row_m1),
        .inst_num_col_m1 (inst_num_col_m1),
        .txn_valid       (txn_valid),
        .txn_ready       (txn_ready),
        .txn_addr        (txn_addr),
        .txn_alen        (txn_alen),
        .txn_is_first    (txn_is_first),
        .txn_is_last     (txn_is_last),
        .resp_valid      (resp_valid),
        .resp_error      (resp_error),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [15:0] stride;
        logic [7:0]  nrow_m1;
        logic [7:0]  ncol_m1;
        int          err_row;
        logic        exp_err;
        int          rdy_mode;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic        first;
        logic        last;
        logic        err;
    } exp_t;

    typedef struct {
        int   due;
        logic err;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];
    vec_t  vecs[7];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_issued = 0;
    int   n_resp = 0;
    int   done_seen = 0;
    int   last_resp_cyc = 0;
    int   ready_mode = 1;
    int   resp_allow = 0;
    logic resp_hold = 1'b0;
    logic exp_err_cur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor, scoreboard and responder: owns txn_ready and resp_valid/resp_error, works on the falling edge.
    initial begin
        exp_t        e;
        resp_t       r;
        logic        stall_prev = 1'b0;
        logic        done_prev = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_misc = '0;
        txn_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       txn_ready = 1'b0;
                1:       txn_ready = 1'b1;
                default: txn_ready = 1'($urandom_range(0, 1));
            endcase
            if (!rstnn) begin
                stall_prev = 1'b0;
            end else if (stall_prev) begin
                chk("stall_valid_held", {31'b0, txn_valid}, 32'd1);
                chk("stall_addr_held", txn_addr, prev_addr);
                chk("stall_info_held", {22'b0, txn_is_last, txn_is_first, txn_alen}, prev_misc);
            end
            if (rstnn && txn_valid && txn_ready) begin
                if (exp_q.size() == 0) begin
                    chk("txn_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_addr", txn_addr, e.addr);
                    chk("txn_info", {22'b0, txn_is_last, txn_is_first, txn_alen},
                        {22'b0, e.last, e.first, e.alen});
                    r.due = cyc + 3;
                    r.err = e.err;
                    resp_q.push_back(r);
                    n_issued++;
                end
            end
            stall_prev = rstnn && txn_valid && !txn_ready;
            prev_addr  = txn_addr;
            prev_misc  = {22'b0, txn_is_last, txn_is_first, txn_alen};

            resp_valid = 1'b0;
            resp_error = 1'b0;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc && (!resp_hold || n_resp < resp_allow)) begin
                r = resp_q.pop_front();
                resp_valid    = 1'b1;
                resp_error    = r.err;
                n_resp++;
                last_resp_cyc = cyc;
            end

            if (done === 1'b1) begin
                done_seen++;
                chk("done_error", {31'b0, error}, {31'b0, exp_err_cur});
                chk("done_latency", cyc - last_resp_cyc, 32'd2);
                chk("done_one_cycle", {31'b0, done_prev}, 32'd0);
            end
            done_prev = (done === 1'b1);
        end
    end

    task automatic push_rows(input vec_t v);
        exp_t e;
        for (int r = 0; r <= int'(v.nrow_m1); r++) begin
            e.addr  = v.addr + 32'(r) * {13'b0, v.stride, 3'b000};
            e.alen  = v.ncol_m1;
            e.first = (r == 0);
            e.last  = (r == int'(v.nrow_m1));
            e.err   = (r == v.err_row);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_inst(input vec_t v);
        @(posedge clk);
        #1;
        chk("inst_ready_idle", {31'b0, inst_ready}, 32'd1);
        inst_valid      = 1'b1;
        inst_addr       = v.addr;
        inst_stride_ls3 = v.stride;
        inst_num_row_m1 = v.nrow_m1;
        inst_num_col_m1 = v.ncol_m1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int base_d);
        int w = 0;
        while (done_seen == base_d && w < 3000) begin
            @(posedge clk);
            w++;
        end
        chk("done_count", done_seen - base_d, 32'd1);
        #1;
        chk("ready_after_done", {31'b0, inst_ready}, 32'd1);
        chk("rows_left", exp_q.size(), 32'd0);
    endtask

    task automatic run_inst(input vec_t v);
        int base_d = done_seen;
        push_rows(v);
        exp_err_cur = v.exp_err;
        ready_mode  = v.rdy_mode;
        drive_inst(v);
        wait_done(base_d);
    endtask

    initial begin
        vec_t v;
        int   base_i;
        int   base_d;
        int   w;

        vecs[0] = '{32'h0000_1000, 16'd2,     8'd3, 8'd3,  -1, 1'b0, 1};
        vecs[1] = '{32'h0000_2000, 16'd4,     8'd3, 8'd7,   2, 1'b1, 1};
        vecs[2] = '{32'h0000_3000, 16'd1,     8'd0, 8'd0,  -1, 1'b0, 1};
        vecs[3] = '{32'hFFFF_FFF8, 16'd1,     8'd1, 8'd15, -1, 1'b0, 1};
        vecs[4] = '{32'h0000_4000, 16'd0,     8'd2, 8'd1,  -1, 1'b0, 1};
        vecs[5] = '{32'h0000_5000, 16'h0020,  8'd5, 8'd2,  -1, 1'b0, 2};
        vecs[6] = '{32'h0000_6000, 16'd3,     8'd9, 8'd0,   7, 1'b1, 2};

        rstnn           = 1'b0;
        inst_valid      = 1'b0;
        inst_addr       = '0;
        inst_stride_ls3 = '0;
        inst_num_row_m1 = '0;
        inst_num_col_m1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst_ready", {31'b0, inst_ready}, 32'd1);
        chk("rst_txn_valid", {31'b0, txn_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_txn_addr", txn_addr, 32'd0);
        chk("rst_txn_alen", {24'b0, txn_alen}, 32'd0);
        chk("rst_first_last", {30'b0, txn_is_first, txn_is_last}, 32'd0);
        rstnn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'b0, inst_ready}, 32'd1);

        foreach (vecs[i]) run_inst(vecs[i]);

        // Outstanding limit: responses withheld, exactly four rows issue, one release lets the fifth out next cycle.
        v = '{32'h0000_8000, 16'd8, 8'd7, 8'd1, -1, 1'b0, 1};
        base_i      = n_issued;
        base_d      = done_seen;
        resp_hold   = 1'b1;
        resp_allow  = n_resp;
        exp_err_cur = 1'b0;
        ready_mode  = 1;
        push_rows(v);
        drive_inst(v);
        repeat (15) @(posedge clk);
        #1;
        chk("held_issued", n_issued - base_i, 32'd4);
        chk("held_txn_valid", {31'b0, txn_valid}, 32'd0);
        resp_allow = n_resp + 1;
        @(posedge clk);
        #1;
        chk("release_issued_before", n_issued - base_i, 32'd4);
        @(posedge clk);
        #1;
        chk("release_fifth_txn", n_issued - base_i, 32'd5);
        resp_hold = 1'b0;
        wait_done(base_d);

        // Reset during ISSUE with two rows outstanding.
        v = '{32'h0000_9000, 16'd2, 8'd7, 8'd3, -1, 1'b0, 1};
        base_i     = n_issued;
        base_d     = done_seen;
        resp_hold  = 1'b1;
        resp_allow = n_resp;
        ready_mode = 1;
        push_rows(v);
        drive_inst(v);
        w = 0;
        while (n_issued - base_i < 2 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        ready_mode = 0;
        chk("rst_mid_issued", n_issued - base_i, 32'd2);
        rstnn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", {31'b0, inst_ready}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_txn_valid", {31'b0, txn_valid}, 32'd0);
        rstnn = 1'b1;
        exp_q.delete();
        resp_hold = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_seen - base_d, 32'd0);
        chk("rst_mid_late_resp_idle", {31'b0, busy}, 32'd0);
        chk("rst_mid_resp_drained", resp_q.size(), 32'd0);

        run_inst(vecs[0]);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
